m0_cmd_master: RTL

// - Bus-master front end driving the M0 port of the DMAC/multiplier/RAM subsystem (upstream of the bus arbiter).
// - Buffers host write/read commands in a FIFO, requests the bus, and issues one transfer per granted cycle.
// - Returns read data with its address as a response pulse.
// - Lets a host program DMAC/multiplier registers and fill/read operand and result RAMs without tracking grant timing.

---
 rtl/m0_master_pkg.sv | 13 +
 rtl/m0_cmd_fifo.sv | 39 +++
 rtl/m0_cmd_master.sv | 108 ++++++++++
 3 files changed

// File: rtl/m0_master_pkg.sv
// m0_master_pkg: shared FSM encoding and command record layout for the M0 bus master
package m0_master_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_XFER = 2'd2, S_GAP = 2'd3} state_t;
  function automatic int cmd_w(input int aw, input int dw);
    return aw + dw + 1;
  endfunction
  function automatic int wr_ofs(input int aw, input int dw);
    return aw + dw;
  endfunction
  function automatic int addr_ofs(input int dw);
    return dw;
  endfunction
endpackage

// File: rtl/m0_cmd_fifo.sv
// m0_cmd_fifo: synchronous command FIFO with head-of-queue read and occupancy count
module m0_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 41
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_en, rd_en;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rp];
  // storage needs no reset; only entries behind the write pointer are ever read
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/m0_cmd_master.sv
// m0_cmd_master: queues host commands and issues them as M0 bus beats, returning read responses
module m0_cmd_master
  import m0_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              M0_req,
  input  logic              M0_grant,
  output logic              M0_wr,
  output logic [ADDR_W-1:0] M0_address,
  output logic [DATA_W-1:0] M0_dout,
  input  logic [DATA_W-1:0] M_din
);
  localparam int CW   = cmd_w(ADDR_W, DATA_W);
  localparam int WR_O = wr_ofs(ADDR_W, DATA_W);
  localparam int AD_O = addr_ofs(DATA_W);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(MAX_BURST + 1);
  state_t state;
  logic [BW-1:0] beats;
  logic [PW:0] fifo_cnt;
  logic [CW-1:0] head;
  logic [ADDR_W-1:0] rd_addr;
  logic fifo_full, fifo_empty, push, issue, drain, rd_pend;
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign issue      = state == S_XFER && M0_grant && !fifo_empty;
  assign drain      = fifo_cnt == (PW+1)'(1) && !push;
  assign M0_wr      = issue && head[WR_O];
  assign M0_address = issue ? head[AD_O +: ADDR_W] : '0;
  assign M0_dout    = M0_wr ? head[DATA_W-1:0] : '0;
  assign busy       = state != S_IDLE || !fifo_empty || rd_pend || rsp_valid;
  m0_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .din   ({cmd_wr, cmd_addr, cmd_wdata}),
    .head  (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // bus tenure control: request, transfer, and a one-cycle release after a full burst
  always_ff @(posedge clk)
    if (reset) begin
      state  <= S_IDLE;
      M0_req <= 1'b0;
      beats  <= '0;
    end else
      case (state)
        S_IDLE: if (!fifo_empty) begin
          state  <= S_REQ;
          M0_req <= 1'b1;
          beats  <= '0;
        end
        S_REQ: if (M0_grant) state <= S_XFER;
        S_XFER:
          if (!M0_grant) state <= S_REQ;
          else if (fifo_empty || drain) begin
            state  <= S_IDLE;
            M0_req <= 1'b0;
          end else begin
            beats <= beats + 1'b1;
            if (beats == BW'(MAX_BURST - 1)) begin
              state  <= S_GAP;
              M0_req <= 1'b0;
            end
          end
        S_GAP: if (!fifo_empty) begin
          state  <= S_REQ;
          M0_req <= 1'b1;
          beats  <= '0;
        end else state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
  // read data arrives one cycle after the address beat; capture it and pulse rsp_valid
  always_ff @(posedge clk)
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      rd_pend   <= issue && !head[WR_O];
      if (issue && !head[WR_O]) rd_addr <= head[AD_O +: ADDR_W];
      rsp_valid <= rd_pend;
      if (rd_pend) begin
        rsp_addr  <= rd_addr;
        rsp_rdata <= M_din;
      end
    end
endmodule
